// File: rtl/a_definitions.sv
// Shared definitions for the arbiter link: FSM states and the fixed
// wire codes of every frame exchanged with the arbiter master port.
// Codes are written in wire order, leftmost bit transmitted first.
package a_definitions;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_REQ_TX     = 4'd1,
        ST_WAIT_GRANT = 4'd2,
        ST_ACK_TX     = 4'd3,
        ST_WAIT_COM   = 4'd4,
        ST_COM        = 4'd5,
        ST_END_TX     = 4'd6,
        ST_DONE_TX    = 4'd7,
        ST_SPLIT_WAIT = 4'd8,
        ST_BACKOFF    = 4'd9
    } state_e;

    // Frames received from the port
    localparam logic [2:0] FR_GRANT       = 3'b110;
    localparam logic [2:0] FR_SPLIT_GRANT = 3'b100;
    localparam logic [2:0] FR_COM_START   = 3'b111;

    // Frames sent to the port
    localparam logic [2:0] FR_REQ_HDR     = 3'b111;
    localparam logic [2:0] FR_ACK         = 3'b101;
    localparam logic [2:0] FR_NAK         = 3'b110;
    localparam logic [1:0] FR_END         = 2'b01;
    localparam logic [2:0] FR_DONE        = 3'b010;

endpackage

// File: rtl/m_frame_rx.sv
// 3-bit frame deserializer. A 1 on the line while idle starts a frame;
// the next two bits complete it. frame_valid is asserted during the
// cycle the third bit is on the line, with frame holding all three bits.
module m_frame_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       bit_in,
    output logic       frame_valid,
    output logic [2:0] frame
);

    logic       busy_q, busy_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] sh_q, sh_d;

    assign frame_valid = busy_q && (cnt_q == 2'd2);
    assign frame       = {sh_q, bit_in};

    // Next-state: start on a 1, collect two more bits, then return idle
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        sh_d   = sh_q;
        if (!busy_q) begin
            if (bit_in) begin
                busy_d = 1'b1;
                cnt_d  = 2'd1;
                sh_d   = 2'b01;
            end
        end else if (cnt_q == 2'd2) begin
            busy_d = 1'b0;
            cnt_d  = 2'd0;
            sh_d   = 2'b00;
        end else begin
            cnt_d = cnt_q + 2'd1;
            sh_d  = {sh_q[0], bit_in};
        end
    end

    // Receiver registers; clear drops any partial frame
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            busy_q <= 1'b0;
            cnt_q  <= 2'd0;
            sh_q   <= 2'b00;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
        end
    end

endmodule

// File: rtl/m_arb_link.sv
// Serial link between a bus master core and the arbiter master port.
// Sends requests, answers grants with ACK/NAK, tracks ownership of the
// bus and handles split stop / split resume. Every transmitted bit comes
// from a register, so arb_out follows an FSM decision by one cycle.
module m_arb_link
    import a_definitions::*;
#(
    parameter int NO_SLAVES  = 3,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
    parameter int BACKOFF    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arb_in,
    output logic                  arb_out,
    input  logic                  req,
    input  logic [S_ID_WIDTH-1:0] req_id,
    input  logic                  ready,
    input  logic                  com_done,
    output logic                  granted,
    output logic                  split,
    output logic                  resumed,
    output logic [3:0]            state_dbg
);

    localparam int TX_W  = 3 + S_ID_WIDTH;
    localparam int CNT_W = $clog2(TX_W + 1);
    localparam int BO_W  = $clog2(BACKOFF + 1);

    state_e            state_q, state_d;
    logic              ack_q, ack_d;        // pending answer is ACK (1) or NAK (0)
    logic              resume_q, resume_d;  // current grant resumes a split transfer
    logic              granted_q, granted_d;
    logic              split_q, split_d;
    logic              resumed_q, resumed_d;
    logic [BO_W-1:0]   bo_q, bo_d;
    logic [TX_W-1:0]   tx_sh_q, tx_sh_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;

    logic              tx_load;
    logic [TX_W-1:0]   tx_frame;
    logic [CNT_W-1:0]  tx_len;
    logic              tx_last;

    logic              rx_valid;
    logic [2:0]        rx_frame;
    logic              rx_clear;

    // Any state change discards partially received bits
    assign rx_clear = (state_d != state_q);

    m_frame_rx u_rx (
        .clk         (clk),
        .rst         (rst),
        .clear       (rx_clear),
        .bit_in      (arb_in),
        .frame_valid (rx_valid),
        .frame       (rx_frame)
    );

    assign arb_out   = tx_sh_q[TX_W-1];
    assign tx_last   = (tx_cnt_q == CNT_W'(1));
    assign granted   = granted_q;
    assign split     = split_q;
    assign resumed   = resumed_q;
    assign state_dbg = state_q;

    // Transmitter: frames are left-aligned; shifting in zeros idles the line
    always_comb begin
        tx_sh_d  = tx_sh_q << 1;
        tx_cnt_d = tx_cnt_q;
        if (tx_load) begin
            tx_sh_d  = tx_frame;
            tx_cnt_d = tx_len;
        end else if (tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
    end

    // FSM next state, frame loads and status outputs
    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        resume_d  = resume_q;
        granted_d = granted_q;
        split_d   = split_q;
        resumed_d = 1'b0;
        bo_d      = bo_q;
        tx_load   = 1'b0;
        tx_frame  = '0;
        tx_len    = '0;
        case (state_q)
            ST_IDLE: begin
                // req_id is captured straight into the transmit register
                if (req) begin
                    tx_load  = 1'b1;
                    tx_frame = {FR_REQ_HDR, req_id};
                    tx_len   = CNT_W'(TX_W);
                    state_d  = ST_REQ_TX;
                end
            end
            ST_REQ_TX: begin
                if (tx_last) state_d = ST_WAIT_GRANT;
            end
            ST_WAIT_GRANT: begin
                if (rx_valid && (rx_frame == FR_GRANT || rx_frame == FR_SPLIT_GRANT)) begin
                    tx_load = 1'b1;
                    tx_len  = CNT_W'(3);
                    ack_d   = ready;
                    if (ready) tx_frame = {FR_ACK, {S_ID_WIDTH{1'b0}}};
                    else       tx_frame = {FR_NAK, {S_ID_WIDTH{1'b0}}};
                    state_d = ST_ACK_TX;
                end
            end
            ST_ACK_TX: begin
                if (tx_last) begin
                    if (ack_q) begin
                        state_d = ST_WAIT_COM;
                    end else begin
                        bo_d    = '0;
                        state_d = ST_BACKOFF;
                    end
                end
            end
            ST_WAIT_COM: begin
                if (rx_valid && rx_frame == FR_COM_START) begin
                    granted_d = 1'b1;
                    if (resume_q) begin
                        split_d   = 1'b0;
                        resumed_d = 1'b1;
                        resume_d  = 1'b0;
                    end
                    state_d = ST_COM;
                end
            end
            ST_COM: begin
                // com_done takes priority over a coincident split stop
                if (com_done) begin
                    granted_d = 1'b0;
                    tx_load   = 1'b1;
                    tx_frame  = {FR_END, {(TX_W-2){1'b0}}};
                    tx_len    = CNT_W'(2);
                    state_d   = ST_END_TX;
                end else if (arb_in) begin
                    granted_d = 1'b0;
                    split_d   = 1'b1;
                    tx_load   = 1'b1;
                    tx_frame  = {FR_DONE, {S_ID_WIDTH{1'b0}}};
                    tx_len    = CNT_W'(3);
                    state_d   = ST_DONE_TX;
                end
            end
            ST_END_TX: begin
                if (tx_last) state_d = ST_IDLE;
            end
            ST_DONE_TX: begin
                if (tx_last) state_d = ST_SPLIT_WAIT;
            end
            ST_SPLIT_WAIT: begin
                // Resuming a split transfer is always acknowledged
                if (rx_valid && rx_frame == FR_SPLIT_GRANT) begin
                    ack_d    = 1'b1;
                    resume_d = 1'b1;
                    tx_load  = 1'b1;
                    tx_frame = {FR_ACK, {S_ID_WIDTH{1'b0}}};
                    tx_len   = CNT_W'(3);
                    state_d  = ST_ACK_TX;
                end
            end
            ST_BACKOFF: begin
                if (bo_q == BO_W'(BACKOFF - 1)) state_d = ST_IDLE;
                else                             bo_d    = bo_q + BO_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, status and transmitter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            resume_q  <= 1'b0;
            granted_q <= 1'b0;
            split_q   <= 1'b0;
            resumed_q <= 1'b0;
            bo_q      <= '0;
            tx_sh_q   <= '0;
            tx_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            resume_q  <= resume_d;
            granted_q <= granted_d;
            split_q   <= split_d;
            resumed_q <= resumed_d;
            bo_q      <= bo_d;
            tx_sh_q   <= tx_sh_d;
            tx_cnt_q  <= tx_cnt_d;
        end
    end

endmodule

// File: tb/tb_m_arb_link.sv
// Directed bench for m_arb_link: request framing, ACK/NAK, backoff,
// normal completion, split stop/resume, com_done priority and reset.
module tb_m_arb_link;
    import a_definitions::*;

    logic       clk;
    logic       rst;
    logic       arb_in;
    logic       arb_out;
    logic       req;
    logic [1:0] req_id;
    logic       ready;
    logic       com_done;
    logic       granted;
    logic       split;
    logic       resumed;
    logic [3:0] state_dbg;

    int total;
    int bad;

    m_arb_link dut (
        .clk       (clk),
        .rst       (rst),
        .arb_in    (arb_in),
        .arb_out   (arb_out),
        .req       (req),
        .req_id    (req_id),
        .ready     (ready),
        .com_done  (com_done),
        .granted   (granted),
        .split     (split),
        .resumed   (resumed),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check n serial bits on arb_out (MSB of the n-bit field first), one per cycle
    task automatic expect_bits(input string tag, input int n, input logic [7:0] bits);
        for (int i = 0; i < n; i++) begin
            check(tag, 32'(arb_out), 32'(bits[n-1-i]));
            tick();
        end
    endtask

    // Drive a 3-bit frame on arb_in, wire order b[2], b[1], b[0]
    task automatic send_frame(input logic [2:0] b);
        for (int i = 2; i >= 0; i--) begin
            arb_in = b[i];
            tick();
        end
        arb_in = 1'b0;
    endtask

    // Full request / grant / com-start sequence, ending in COM
    task automatic reach_com(input logic [1:0] id);
        req    = 1'b1;
        req_id = id;
        tick();
        req    = 1'b0;
        expect_bits("req_frame", 5, {3'b000, 3'b111, id});
        check("wait_grant_state", 32'(state_dbg), 32'(ST_WAIT_GRANT));
        ready = 1'b1;
        send_frame(3'b110);
        expect_bits("ack_frame", 3, 8'b101);
        check("wait_com_state", 32'(state_dbg), 32'(ST_WAIT_COM));
        check("granted_before_start", 32'(granted), 32'd0);
        send_frame(3'b111);
        check("granted_after_start", 32'(granted), 32'd1);
        check("com_state", 32'(state_dbg), 32'(ST_COM));
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        arb_in   = 1'b0;
        req      = 1'b0;
        req_id   = 2'b00;
        ready    = 1'b0;
        com_done = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_arb_out", 32'(arb_out), 32'd0);
        check("rst_granted", 32'(granted), 32'd0);
        check("rst_split", 32'(split), 32'd0);
        check("rst_resumed", 32'(resumed), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;
        tick();
        check("idle_line", 32'(arb_out), 32'd0);

        // Request id 2'b10 (req dropped after start), ACK, complete with END
        reach_com(2'b10);
        tick();
        tick();
        check("granted_hold", 32'(granted), 32'd1);
        com_done = 1'b1;
        tick();
        com_done = 1'b0;
        check("end_granted", 32'(granted), 32'd0);
        expect_bits("end_frame", 2, 8'b01);
        check("end_idle_state", 32'(state_dbg), 32'(ST_IDLE));
        check("end_line_idle", 32'(arb_out), 32'd0);

        // NAK on ready low, backoff, then re-request with req still high
        req    = 1'b1;
        req_id = 2'b01;
        tick();
        expect_bits("req2_frame", 5, 8'b00011101);
        ready = 1'b0;
        send_frame(3'b110);
        expect_bits("nak_frame", 3, 8'b110);
        check("backoff_state", 32'(state_dbg), 32'(ST_BACKOFF));
        for (int i = 0; i < 9; i++) begin
            check("backoff_quiet", 32'(arb_out), 32'd0);
            tick();
        end
        req = 1'b0;
        expect_bits("rereq_frame", 5, 8'b00011101);
        ready = 1'b1;
        send_frame(3'b110);
        expect_bits("ack2_frame", 3, 8'b101);
        send_frame(3'b111);
        check("granted_rereq", 32'(granted), 32'd1);

        // Split stop 0,1,0 in COM, then split-grant (ready low still ACKs), resume
        arb_in = 1'b0;
        tick();
        arb_in = 1'b1;
        tick();
        arb_in = 1'b0;
        check("split_set", 32'(split), 32'd1);
        check("split_granted", 32'(granted), 32'd0);
        expect_bits("done_frame", 3, 8'b010);
        check("split_wait_state", 32'(state_dbg), 32'(ST_SPLIT_WAIT));
        check("split_hold", 32'(split), 32'd1);
        ready = 1'b0;
        send_frame(3'b100);
        expect_bits("resume_ack", 3, 8'b101);
        check("resume_wait_com", 32'(state_dbg), 32'(ST_WAIT_COM));
        send_frame(3'b111);
        check("resumed_pulse", 32'(resumed), 32'd1);
        check("resumed_granted", 32'(granted), 32'd1);
        check("resumed_split", 32'(split), 32'd0);
        tick();
        check("resumed_one_cycle", 32'(resumed), 32'd0);
        com_done = 1'b1;
        tick();
        com_done = 1'b0;
        expect_bits("end2_frame", 2, 8'b01);
        check("end2_idle", 32'(state_dbg), 32'(ST_IDLE));

        // com_done coincident with split-stop middle bit: END wins
        reach_com(2'b11);
        arb_in = 1'b0;
        tick();
        arb_in   = 1'b1;
        com_done = 1'b1;
        tick();
        arb_in   = 1'b0;
        com_done = 1'b0;
        check("coinc_split", 32'(split), 32'd0);
        check("coinc_granted", 32'(granted), 32'd0);
        expect_bits("coinc_end", 2, 8'b01);
        check("coinc_idle", 32'(state_dbg), 32'(ST_IDLE));
        check("coinc_split_after", 32'(split), 32'd0);
        check("coinc_line", 32'(arb_out), 32'd0);

        // Reset in COM: outputs drop next cycle, no END frame follows
        reach_com(2'b01);
        rst = 1'b1;
        tick();
        check("rst_com_granted", 32'(granted), 32'd0);
        check("rst_com_split", 32'(split), 32'd0);
        check("rst_com_line", 32'(arb_out), 32'd0);
        check("rst_com_state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_com_quiet", 32'(arb_out), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
